// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default bit timing.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START      = 3'd1,
    DATA       = 3'd2,
    STOP       = 3'd3,
    BREAK_WAIT = 3'd4
  } rx_state_t;

  localparam int CLK_HZ               = 100_000_000;
  localparam int BAUD                 = 115200;
  localparam int CLKS_PER_BIT_DEFAULT = CLK_HZ / BAUD;

endpackage

// File: rtl/uart_rx_ctrl.sv
// 8N1-style UART receive sequencer: centre-samples each bit of the synchronized
// line, strobes good bytes and flags frames whose stop bit is low.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rx_sync,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_error,
  output logic                 busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam int HALF  = CLKS_PER_BIT / 2;

  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] BIT_M1   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  rx_state_t            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 busy_q;

  // Next-state, bit timer and strobe decode
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_sync) begin
          state_d = START;
          cnt_d   = {CNT_W{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        // A start bit that is high again at its centre was only a glitch
        if (cnt_q == HALF_M1) begin
          if (!rx_sync) begin
            state_d = DATA;
            cnt_d   = {CNT_W{1'b0}};
            idx_d   = {IDX_W{1'b0}};
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      DATA: begin
        if (cnt_q == BIT_M1) begin
          shift_d[idx_q] = rx_sync;
          cnt_d          = {CNT_W{1'b0}};
          if (idx_q == LAST_IDX) begin
            state_d = STOP;
            idx_d   = {IDX_W{1'b0}};
          end else begin
            idx_d = idx_q + IDX_ONE;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      STOP: begin
        if (cnt_q == BIT_M1) begin
          cnt_d = {CNT_W{1'b0}};
          if (rx_sync) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = BREAK_WAIT;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      BREAK_WAIT: begin
        // A held-low line must return high before another frame can start
        if (rx_sync) begin
          state_d = IDLE;
        end else begin
          state_d = BREAK_WAIT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      idx_q   <= {IDX_W{1'b0}};
      shift_q <= {DATA_BITS{1'b0}};
      data_q  <= {DATA_BITS{1'b0}};
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      busy_q  <= (state_q != IDLE);
    end
  end

  assign rx_data     = data_q;
  assign rx_valid    = valid_q;
  assign frame_error = ferr_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Randomized bench for uart_rx_ctrl: an 8-bit and a 5-bit receiver share one line
// and are compared every cycle against a frame-timing model, plus directed cases.
module tb_uart_rx_ctrl;

  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;

  logic       clock = 1'b0;
  logic       reset;
  logic       rx_sync;
  logic [7:0] rx_data8;
  logic [4:0] rx_data5;
  logic       v8, e8, b8, v5, e5, b5;

  always #5 clock = ~clock;

  uart_rx_ctrl #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut8 (
    .clock(clock), .reset(reset), .rx_sync(rx_sync),
    .rx_data(rx_data8), .rx_valid(v8), .frame_error(e8), .busy(b8)
  );

  uart_rx_ctrl #(.CLKS_PER_BIT(CPB), .DATA_BITS(5)) dut5 (
    .clock(clock), .reset(reset), .rx_sync(rx_sync),
    .rx_data(rx_data5), .rx_valid(v5), .frame_error(e5), .busy(b5)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: a frame is a start time T; every decision is a fixed offset from T.
  typedef enum {M_IDLE, M_FRAME, M_BREAK} mode_t;
  mode_t      m_mode [2];
  int         m_t0   [2];
  logic [7:0] m_sh   [2];
  logic [7:0] e_data [2];
  logic       e_valid[2];
  logic       e_err  [2];
  logic       e_busy [2];
  int         db     [2] = '{8, 5};
  int         el, k;

  always @(posedge clock) begin
    cyc = cyc + 1;
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_mode[i]  = M_IDLE;
        m_sh[i]    = 8'h00;
        e_data[i]  = 8'h00;
        e_valid[i] = 1'b0;
        e_err[i]   = 1'b0;
        e_busy[i]  = 1'b0;
      end else begin
        e_busy[i]  = (m_mode[i] != M_IDLE);
        e_valid[i] = 1'b0;
        e_err[i]   = 1'b0;
        case (m_mode[i])
          M_IDLE: if (!rx_sync) begin
            m_t0[i]   = cyc;
            m_mode[i] = M_FRAME;
          end
          M_FRAME: begin
            el = cyc - m_t0[i];
            if (el == HALF) begin
              if (rx_sync) m_mode[i] = M_IDLE;
            end else if (el > HALF && ((el - HALF) % CPB) == 0) begin
              k = (el - HALF) / CPB - 1;
              if (k < db[i]) begin
                m_sh[i][k] = rx_sync;
              end else if (rx_sync) begin
                e_valid[i] = 1'b1;
                e_data[i]  = m_sh[i];
                m_mode[i]  = M_IDLE;
              end else begin
                e_err[i]  = 1'b1;
                m_mode[i] = M_BREAK;
              end
            end
          end
          default: if (rx_sync) m_mode[i] = M_IDLE;
        endcase
      end
    end
  end

  // Per-cycle compare plus logs of strobes (logged cycle = cycle the strobe is high)
  logic [7:0] v0_d[$];
  int         v0_c[$];
  logic [7:0] v1_d[$];
  int         v1_c[$];
  int         e0_n = 0;

  always @(negedge clock) begin
    if (cyc > 0) begin
      chk("valid8", v8, e_valid[0]);
      chk("ferr8",  e8, e_err[0]);
      chk("busy8",  b8, e_busy[0]);
      chk("data8",  rx_data8, e_data[0]);
      chk("valid5", v5, e_valid[1]);
      chk("ferr5",  e5, e_err[1]);
      chk("busy5",  b5, e_busy[1]);
      chk("data5",  {3'b000, rx_data5}, e_data[1]);
      if (v8 === 1'b1) begin
        v0_d.push_back(rx_data8);
        v0_c.push_back(cyc + 1);
      end
      if (e8 === 1'b1) e0_n++;
      if (v5 === 1'b1) begin
        v1_d.push_back({3'b000, rx_data5});
        v1_c.push_back(cyc + 1);
      end
    end
  end

  task automatic hold(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      rx_sync = v;
      @(negedge clock);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input int nb, input logic stop, output int t0);
    t0 = cyc + 1;
    hold(1'b0, CPB);
    for (int i = 0; i < nb; i++) hold(b[i], CPB);
    hold(stop, CPB);
  endtask

  task automatic clear_logs();
    v0_d.delete(); v0_c.delete(); v1_d.delete(); v1_c.delete();
    e0_n = 0;
  endtask

  int t0, t1, nb;
  logic stop;

  initial begin
    rx_sync = 1'b1;
    reset   = 1'b1;
    repeat (3) @(negedge clock);
    chk("reset_data",  rx_data8, 8'h00);
    chk("reset_valid", v8, 1'b0);
    chk("reset_ferr",  e8, 1'b0);
    chk("reset_busy",  b8, 1'b0);
    reset = 1'b0;
    hold(1'b1, 10);

    // Single good byte
    clear_logs();
    send_frame(8'h55, 8, 1'b1, t0);
    hold(1'b1, 20);
    chk("x55_count", v0_d.size(), 1);
    if (v0_d.size() == 1) begin
      chk("x55_data", v0_d[0], 8'h55);
      chk("x55_time", v0_c[0] - t0, 153);
    end
    chk("x55_ferr", e0_n, 0);
    chk("model_x55", e_data[0], 8'h55);

    // Back-to-back frames with no idle gap
    clear_logs();
    send_frame(8'hA5, 8, 1'b1, t0);
    send_frame(8'h3C, 8, 1'b1, t1);
    hold(1'b1, 20);
    chk("b2b_count", v0_d.size(), 2);
    if (v0_d.size() == 2) begin
      chk("b2b_first",   v0_d[0], 8'hA5);
      chk("b2b_second",  v0_d[1], 8'h3C);
      chk("b2b_spacing", v0_c[1] - v0_c[0], 160);
    end

    // Short low glitch on the line
    clear_logs();
    t0 = cyc + 1;
    hold(1'b0, 4);
    hold(1'b1, 2);
    chk("glitch_busy_hi", b8, 1'b1);
    hold(1'b1, 7);
    chk("glitch_busy_lo", b8, 1'b0);
    hold(1'b1, 10);
    chk("glitch_valid", v0_d.size(), 0);
    chk("glitch_ferr",  e0_n, 0);

    // Framing error followed by a held break, then a good byte
    clear_logs();
    send_frame(8'hFF, 8, 1'b0, t0);
    hold(1'b0, 50);
    hold(1'b1, 30);
    chk("brk_ferr",  e0_n, 1);
    chk("brk_valid", v0_d.size(), 0);
    chk("brk_hold",  rx_data8, 8'h3C);
    send_frame(8'h12, 8, 1'b1, t0);
    hold(1'b1, 20);
    chk("brk_next_count", v0_d.size(), 1);
    if (v0_d.size() == 1) chk("brk_next_data", v0_d[0], 8'h12);

    // Reset in the middle of data bit 3
    clear_logs();
    hold(1'b0, CPB);
    hold(1'b1, CPB);
    hold(1'b0, CPB);
    hold(1'b0, CPB);
    hold(1'b0, HALF);
    rx_sync = 1'b1;
    reset   = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("rst_data",  rx_data8, 8'h00);
    chk("rst_valid", v8, 1'b0);
    chk("rst_ferr",  e8, 1'b0);
    chk("rst_busy",  b8, 1'b0);
    hold(1'b1, 20);
    chk("rst_nostrobe", v0_d.size() + e0_n, 0);
    send_frame(8'h81, 8, 1'b1, t0);
    hold(1'b1, 20);
    chk("rst_next_count", v0_d.size(), 1);
    if (v0_d.size() == 1) chk("rst_next_data", v0_d[0], 8'h81);

    // Five data bits on the narrow receiver
    clear_logs();
    send_frame(8'h15, 5, 1'b1, t0);
    hold(1'b1, 30);
    chk("db5_count", v1_d.size(), 1);
    if (v1_d.size() == 1) begin
      chk("db5_data", v1_d[0], 8'h15);
      chk("db5_time", v1_c[0] - t0, 105);
    end
    chk("model_db5", e_data[1], 8'h15);

    // Random traffic: glitches, both widths, bad stop bits, random gaps
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        hold(1'b0, $urandom_range(1, HALF - 1));
        hold(1'b1, $urandom_range(1, 20));
      end else begin
        nb   = ($urandom_range(0, 3) == 0) ? 5 : 8;
        stop = ($urandom_range(0, 4) != 0);
        send_frame(8'($urandom), nb, stop, t0);
        if (!stop) hold(1'b0, $urandom_range(0, 40));
        hold(1'b1, $urandom_range(0, 30));
      end
    end
    hold(1'b1, 200);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
